// File: rtl/ctx_save_restore.sv
// Interrupt context engine: saves R0..R3 onto a LIFO shadow stack on entry and
// writes them back on return, stalling the core through busy while it owns the register file.
module ctx_save_restore #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         save_req,
  input  logic                         restore_req,
  input  logic                         clr_err,
  output logic [$clog2(NUM_REGS)-1:0]  rf_ReadReg,
  input  logic [DATA_W-1:0]            rf_ReadData,
  output logic                         rf_RegWrite,
  output logic [$clog2(NUM_REGS)-1:0]  rf_WriteReg,
  output logic [DATA_W-1:0]            rf_WriteData,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   nest_level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
  localparam logic [IW-1:0] ONE_I    = IW'(1);
  localparam logic [NW-1:0] ONE_N    = NW'(1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);
  localparam logic [LW-1:0] ONE_L    = LW'(1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, FINISH} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NW-1:0]      nest_q, nest_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [DATA_W-1:0]  stack_q [DEPTH][NUM_REGS];

  // Stack slot addressing; the restore slot wraps correctly because nest_level never exceeds DEPTH.
  logic [LW-1:0]      save_lvl;
  logic [LW-1:0]      rest_lvl;
  assign save_lvl = nest_q[LW-1:0];
  assign rest_lvl = nest_q[LW-1:0] - ONE_L;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nest_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nest_q  <= nest_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < DEPTH; l++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          stack_q[l][r] <= '0;
        end
      end
    end else if (state_q == SAVE) begin
      stack_q[save_lvl][idx_q] <= rf_ReadData;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nest_d  = nest_q;
    // A new error in the same cycle as clr_err overrides the clear below.
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    case (state_q)
      IDLE: begin
        if (save_req) begin
          if (nest_q < DEPTH_N) begin
            state_d = SAVE;
            idx_d   = '0;
          end else begin
            state_d = FINISH;
            ovf_d   = 1'b1;
          end
        end else if (restore_req) begin
          if (nest_q != '0) begin
            state_d = RESTORE;
            idx_d   = '0;
          end else begin
            state_d = FINISH;
            unf_d   = 1'b1;
          end
        end
      end
      SAVE: begin
        idx_d = idx_q + ONE_I;
        if (idx_q == LAST_IDX) begin
          nest_d  = nest_q + ONE_N;
          state_d = FINISH;
        end
      end
      RESTORE: begin
        idx_d = idx_q + ONE_I;
        if (idx_q == LAST_IDX) begin
          nest_d  = nest_q - ONE_N;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_ReadReg   = '0;
    rf_RegWrite  = 1'b0;
    rf_WriteReg  = '0;
    rf_WriteData = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      SAVE: begin
        busy       = 1'b1;
        rf_ReadReg = idx_q;
      end
      RESTORE: begin
        busy         = 1'b1;
        rf_RegWrite  = 1'b1;
        rf_WriteReg  = idx_q;
        rf_WriteData = stack_q[rest_lvl][idx_q];
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign nest_level = nest_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_ctx_save_restore.sv
// Bench for ctx_save_restore: models the register file plus a LIFO of saved contexts
// and checks every cycle of each request against that model.
module tb_ctx_save_restore;
  localparam int NR    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       save_req = 1'b0, restore_req = 1'b0, clr_err = 1'b0;
  logic [1:0] rf_ReadReg, rf_WriteReg;
  logic [7:0] rf_ReadData, rf_WriteData;
  logic       rf_RegWrite, busy, done;
  logic [2:0] nest_level;
  logic       overflow, underflow;

  logic [7:0] rf [4];
  logic       core_we = 1'b0;
  logic [1:0] core_wreg = '0;
  logic [7:0] core_wdata = '0;

  logic [7:0]  m_rf [4];
  logic [31:0] mstack [$];
  bit          m_ovf = 1'b0, m_unf = 1'b0;

  int checks = 0;
  int errors = 0;

  ctx_save_restore #(.NUM_REGS(4), .DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .clr_err(clr_err), .rf_ReadReg(rf_ReadReg), .rf_ReadData(rf_ReadData),
    .rf_RegWrite(rf_RegWrite), .rf_WriteReg(rf_WriteReg), .rf_WriteData(rf_WriteData),
    .busy(busy), .done(done), .nest_level(nest_level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Register file with the core/engine write-port mux selected by busy.
  assign rf_ReadData = rf[rf_ReadReg];
  always @(posedge clk) begin
    if (busy) begin
      if (rf_RegWrite) rf[rf_WriteReg] <= rf_WriteData;
    end else if (core_we) begin
      rf[core_wreg] <= core_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet_ports(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_regwrite"}, rf_RegWrite, 0);
    chk({tag, "_readreg"}, rf_ReadReg, 0);
    chk({tag, "_writereg"}, rf_WriteReg, 0);
    chk({tag, "_writedata"}, rf_WriteData, 0);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_nest"}, nest_level, mstack.size());
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_unf"}, underflow, m_unf);
  endtask

  task automatic core_write(input int r, input logic [7:0] v);
    core_we = 1'b1; core_wreg = 2'(r); core_wdata = v;
    @(negedge clk);
    core_we = 1'b0;
    m_rf[r] = v;
  endtask

  task automatic write_all(input logic [31:0] v);
    for (int i = 0; i < NR; i++) core_write(i, v[8*i +: 8]);
  endtask

  // kind: 0 no request, 1 save, 2 restore, 3 rejected save, 4 rejected restore
  task automatic do_req(input bit s, input bit r, input bit c);
    int kind;
    logic [31:0] ctx;
    save_req = s; restore_req = r; clr_err = c;
    if (s)      kind = (mstack.size() < DEPTH) ? 1 : 3;
    else if (r) kind = (mstack.size() > 0) ? 2 : 4;
    else        kind = 0;
    if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (kind == 3) m_ovf = 1'b1;
    if (kind == 4) m_unf = 1'b1;
    @(negedge clk);
    save_req = 1'b0; restore_req = 1'b0; clr_err = 1'b0;
    if (kind == 1) begin
      ctx = {m_rf[3], m_rf[2], m_rf[1], m_rf[0]};
      for (int i = 0; i < NR; i++) begin
        chk("save_busy", busy, 1);
        chk("save_readreg", rf_ReadReg, i);
        chk("save_regwrite", rf_RegWrite, 0);
        chk("save_done", done, 0);
        save_req = 1'($urandom_range(0, 1));
        restore_req = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      mstack.push_back(ctx);
    end else if (kind == 2) begin
      ctx = mstack.pop_back();
      for (int i = 0; i < NR; i++) begin
        chk("rest_busy", busy, 1);
        chk("rest_regwrite", rf_RegWrite, 1);
        chk("rest_writereg", rf_WriteReg, i);
        chk("rest_writedata", rf_WriteData, ctx[8*i +: 8]);
        chk("rest_done", done, 0);
        save_req = 1'($urandom_range(0, 1));
        restore_req = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      for (int i = 0; i < NR; i++) m_rf[i] = ctx[8*i +: 8];
    end
    chk("done", done, (kind != 0) ? 1 : 0);
    chk_quiet_ports("finish");
    chk_status("finish");
    if (kind == 2) for (int i = 0; i < NR; i++) chk("rf_restored", rf[i], m_rf[i]);
    if (kind != 0) begin
      save_req = 1'($urandom_range(0, 1));
      restore_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      save_req = 1'b0; restore_req = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  // Reset asserted asynchronously k cycles into a save or restore sequence.
  task automatic reset_mid(input bit is_save, input int k);
    logic [31:0] ctx;
    ctx = '0;
    if (!is_save) ctx = mstack[mstack.size() - 1];
    if (is_save) save_req = 1'b1; else restore_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0; restore_req = 1'b0;
    repeat (k) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    if (!is_save) for (int i = 0; i < k; i++) m_rf[i] = ctx[8*i +: 8];
    mstack.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    chk("rst_done", done, 0);
    chk_quiet_ports("rst");
    chk_status("rst");
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("rst_no_done", done, 0);
      chk("rst_no_busy", busy, 0);
      @(negedge clk);
    end
    for (int i = 0; i < NR; i++) chk("rst_rf_kept", rf[i], m_rf[i]);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_done", done, 0);
    chk_quiet_ports("reset");
    chk_status("reset");
    @(negedge clk);
    reset = 1'b0;

    write_all(32'h7FAA0305);
    do_req(1, 0, 0);
    write_all(32'h00000000);
    do_req(0, 1, 0);

    write_all(32'h04030201);
    do_req(1, 0, 0);
    write_all(32'h14131211);
    do_req(1, 0, 0);
    do_req(0, 1, 0);
    do_req(0, 1, 0);

    for (int n = 0; n < 5; n++) begin
      write_all($urandom);
      do_req(1, 0, 0);
    end
    do_req(1, 0, 1);
    do_req(0, 0, 1);

    repeat (4) do_req(0, 1, 0);
    do_req(0, 1, 0);
    do_req(1, 1, 0);
    do_req(0, 0, 1);

    reset_mid(1'b1, 1);
    do_req(0, 1, 0);
    do_req(0, 0, 1);

    write_all($urandom);
    do_req(1, 0, 0);
    write_all($urandom);
    reset_mid(1'b0, 2);

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        core_write(int'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        do_req(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
